// File: rtl/skolem_exhaustive_checker.sv
// rtl/skolem_exhaustive_checker.sv - exhaustive sweep checker for a Skolem-function candidate
module skolem_exhaustive_checker #(
    parameter int N_IN     = 7,
    parameter int CAND_LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            stop_on_fail,
    input  logic            cand_out,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic            cex_valid,
    output logic [N_IN-1:0] cex_vec,
    output logic            cex_got
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Golden relation is an XNOR chain, which reduces to parity inverted when N_IN is even.
    localparam logic       PAR_INV = 1'((N_IN - 1) % 2);
    localparam logic [2:0] LAT     = 3'(CAND_LAT);

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [2:0]      wait_q, wait_d;
    logic [N_IN:0]   fc_q, fc_d;
    logic            cexv_q, cexv_d;
    logic [N_IN-1:0] cexvec_q, cexvec_d;
    logic            cexgot_q, cexgot_d;
    logic            pass_q, pass_d;
    logic            sof_q, sof_d;

    logic            expected;
    logic            mismatch;

    assign expected = (^vec_q) ^ PAR_INV;
    assign mismatch = cand_out ^ expected;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        wait_d   = wait_q;
        fc_d     = fc_q;
        cexv_d   = cexv_q;
        cexvec_d = cexvec_q;
        cexgot_d = cexgot_q;
        pass_d   = pass_q;
        sof_d    = sof_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    vec_d    = '0;
                    fc_d     = '0;
                    cexv_d   = 1'b0;
                    cexvec_d = '0;
                    cexgot_d = 1'b0;
                    pass_d   = 1'b0;
                    sof_d    = stop_on_fail;
                    wait_d   = LAT;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else if (wait_q == 3'd0) begin
                    state_d = CHECK;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            CHECK: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (mismatch) begin
                        fc_d = fc_q + 1'b1;
                        if (!cexv_q) begin
                            cexv_d   = 1'b1;
                            cexvec_d = vec_q;
                            cexgot_d = cand_out;
                        end
                    end
                    if ((&vec_q) || (mismatch && sof_q)) begin
                        state_d = DONE;
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        wait_d  = LAT;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                pass_d  = abort ? 1'b0 : (fc_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            wait_q   <= '0;
            fc_q     <= '0;
            cexv_q   <= 1'b0;
            cexvec_q <= '0;
            cexgot_q <= 1'b0;
            pass_q   <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            wait_q   <= wait_d;
            fc_q     <= fc_d;
            cexv_q   <= cexv_d;
            cexvec_q <= cexvec_d;
            cexgot_q <= cexgot_d;
            pass_q   <= pass_d;
            sof_q    <= sof_d;
        end
    end

    assign vec        = vec_q;
    assign busy       = (state_q == SETTLE) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign fail_count = fc_q;
    assign cex_valid  = cexv_q;
    assign cex_vec    = cexvec_q;
    assign cex_got    = cexgot_q;

endmodule

// File: tb/tb_skolem_exhaustive_checker.sv
// tb/tb_skolem_exhaustive_checker.sv - directed-vector bench for skolem_exhaustive_checker
module tb_skolem_exhaustive_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_start, a_abort, a_sof, a_cand;
    logic [6:0] a_vec;
    logic       a_busy, a_done, a_pass, a_cexv, a_cexgot;
    logic [7:0] a_fc;
    logic [6:0] a_cexvec;

    logic       b_start, b_cand;
    logic [6:0] b_vec;
    logic       b_busy, b_done, b_pass, b_cexv, b_cexgot;
    logic [7:0] b_fc;
    logic [6:0] b_cexvec;

    int   mode;
    logic a_s1, a_s2, b_s1, b_s2;

    // Candidate models: 0 correct, 1 inverted, 2 stuck-at-0, 3 two-stage registered parity.
    always @(posedge clk) begin
        a_s1 <= ^a_vec;
        a_s2 <= a_s1;
        b_s1 <= ^b_vec;
        b_s2 <= b_s1;
    end

    always_comb begin
        case (mode)
            0:       a_cand = ^a_vec;
            1:       a_cand = ~^a_vec;
            2:       a_cand = 1'b0;
            default: a_cand = a_s2;
        endcase
    end
    assign b_cand = b_s2;

    skolem_exhaustive_checker #(.N_IN(7), .CAND_LAT(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .stop_on_fail(a_sof), .cand_out(a_cand), .vec(a_vec),
        .busy(a_busy), .done(a_done), .pass(a_pass), .fail_count(a_fc),
        .cex_valid(a_cexv), .cex_vec(a_cexvec), .cex_got(a_cexgot)
    );

    skolem_exhaustive_checker #(.N_IN(7), .CAND_LAT(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(1'b0),
        .stop_on_fail(1'b0), .cand_out(b_cand), .vec(b_vec),
        .busy(b_busy), .done(b_done), .pass(b_pass), .fail_count(b_fc),
        .cex_valid(b_cexv), .cex_vec(b_cexvec), .cex_got(b_cexgot)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 0; returns the cycle in which done was seen (-1 if never).
    task automatic run_a(input int md, input logic sof, output int dcyc);
        mode    = md;
        a_sof   = sof;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        dcyc    = -1;
        for (int c = 1; c <= 2000; c++) begin
            if (a_done) begin
                dcyc = c;
                break;
            end
            step();
        end
        step();
    endtask

    int  d;
    logic saw_done;

    initial begin
        rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_sof = 1'b0;
        b_start = 1'b0; mode = 0;
        step();
        step();
        check("rst_vec", a_vec, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_pass", a_pass, 0);
        check("rst_fc", a_fc, 0);
        check("rst_cex", {a_cexv, a_cexvec, a_cexgot}, 0);
        rst = 1'b0;
        step();

        run_a(0, 1'b0, d);
        check("good_done_cyc", d, 257);
        check("good_pass", a_pass, 1);
        check("good_fc", a_fc, 0);
        check("good_cexv", a_cexv, 0);
        check("good_vec", a_vec, 7'h7F);
        check("good_idle", {a_busy, a_done}, 0);

        run_a(1, 1'b0, d);
        check("inv_done_cyc", d, 257);
        check("inv_pass", a_pass, 0);
        check("inv_fc", a_fc, 128);
        check("inv_cexv", a_cexv, 1);
        check("inv_cexvec", a_cexvec, 0);
        check("inv_cexgot", a_cexgot, 1);

        run_a(2, 1'b0, d);
        check("sa0_fc", a_fc, 64);
        check("sa0_cexvec", a_cexvec, 7'h01);
        check("sa0_cexgot", a_cexgot, 0);
        check("sa0_pass", a_pass, 0);

        run_a(2, 1'b1, d);
        check("sof_done_cyc", d, 5);
        check("sof_fc", a_fc, 1);
        check("sof_vec", a_vec, 7'h01);
        check("sof_cexvec", a_cexvec, 7'h01);

        run_a(3, 1'b0, d);
        check("lat_mismatch_pass", a_pass, 0);

        b_start = 1'b1;
        step();
        b_start = 1'b0;
        d = -1;
        for (int c = 1; c <= 2000; c++) begin
            if (b_done) begin
                d = c;
                break;
            end
            step();
        end
        step();
        check("lat2_done_cyc", d, 513);
        check("lat2_pass", b_pass, 1);
        check("lat2_fc", b_fc, 0);

        mode = 0;
        a_sof = 1'b0;
        a_start = 1'b1;
        saw_done = 1'b0;
        step();
        a_start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (a_done) saw_done = 1'b1;
            if (c == 20) a_start = 1'b1;
            if (c == 21) begin
                a_start = 1'b0;
                check("restart_ignored_vec", a_vec, 10);
                check("restart_busy", a_busy, 1);
            end
            if (c == 50) a_abort = 1'b1;
            if (c < 50) step();
        end
        step();
        a_abort = 1'b0;
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        check("abort_vec", a_vec, 24);
        check("abort_pass", a_pass, 0);
        for (int c = 0; c < 5; c++) begin
            if (a_done) saw_done = 1'b1;
            step();
        end
        check("abort_no_done", saw_done, 0);

        mode = 1;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int c = 1; c < 30; c++) step();
        check("pre_rst_fc", a_fc, 14);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_vec", a_vec, 0);
        check("mid_rst_fc", a_fc, 0);
        check("mid_rst_flags", {a_busy, a_done, a_pass}, 0);
        check("mid_rst_cex", {a_cexv, a_cexvec, a_cexgot}, 0);
        step();
        run_a(0, 1'b0, d);
        check("post_rst_done_cyc", d, 257);
        check("post_rst_pass", a_pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
